// File: rtl/inv_out_monitor.sv
// Synchronizes and debounces the looped-back inverter output, counts debounced rising edges and,
// when PERIOD_MEAS_EN is defined, measures high/low run lengths. Results are read through a byte mux.
module inv_out_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 4,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       sense_in,
   input  logic       clr,
   input  logic [2:0] sel,
   output logic [7:0] data_out,
   output logic       level_out,
   output logic       edge_pulse,
   output logic       ovf
);
   localparam int               DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [7:0]       ID_BYTE  = 8'hA5;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DW-1:0]          deb_q, deb_d;
   logic                   level_q, level_d, pulse_q, pulse_d, ovf_q, ovf_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [7:0]             data_q, data_d;
   logic                   s, hit, rise;
   logic [CNT_W-1:0]       hl_w, ll_w;
   logic                   hv_w, lv_w, ps_w;

   // The synchronizer keeps sampling while ena is low so no stale value is released later.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], sense_in};

   assign s    = sync_q[SYNC_STAGES-1];
   assign hit  = (s != level_q) && (deb_q == DEB_LAST);
   assign rise = hit && s;

   always_comb begin
      deb_d   = deb_q;
      level_d = level_q;
      pulse_d = pulse_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (ena) begin
         pulse_d = rise;
         if (s == level_q || hit) deb_d = '0;
         else                     deb_d = deb_q + DW'(1);
         if (hit) level_d = s;
         if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
         end else if (rise) begin
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef PERIOD_MEAS_EN
   logic [CNT_W-1:0] run_q, run_d, hl_q, hl_d, ll_q, ll_d;
   logic             act_q, act_d, hv_q, hv_d, lv_q, lv_d, ps_q, ps_d;

   // Run counter stays idle until a transition gives it a defined start point.
   always_comb begin
      run_d = run_q; act_d = act_q; hl_d = hl_q; ll_d = ll_q;
      hv_d  = hv_q;  lv_d  = lv_q;  ps_d = ps_q;
      if (ena) begin
         if (clr) begin
            run_d = '0; act_d = 1'b0; hl_d = '0; ll_d = '0;
            hv_d  = 1'b0; lv_d = 1'b0; ps_d = 1'b0;
         end else if (hit) begin
            if (act_q) begin
               if (level_q) begin hl_d = run_q; hv_d = 1'b1; end
               else         begin ll_d = run_q; lv_d = 1'b1; end
               if (run_q == CNT_MAX) ps_d = 1'b1;
            end
            run_d = CNT_W'(1);
            act_d = 1'b1;
         end else if (act_q && run_q != CNT_MAX) begin
            run_d = run_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         run_q <= '0; act_q <= 1'b0; hl_q <= '0; ll_q <= '0;
         hv_q  <= 1'b0; lv_q <= 1'b0; ps_q <= 1'b0;
      end else begin
         run_q <= run_d; act_q <= act_d; hl_q <= hl_d; ll_q <= ll_d;
         hv_q  <= hv_d;  lv_q  <= lv_d;  ps_q <= ps_d;
      end

   assign hl_w = hl_q;
   assign ll_w = ll_q;
   assign hv_w = hv_q;
   assign lv_w = lv_q;
   assign ps_w = ps_q;
`else
   assign hl_w = '0;
   assign ll_w = '0;
   assign hv_w = 1'b0;
   assign lv_w = 1'b0;
   assign ps_w = 1'b0;
`endif

   logic [15:0] ec16, hl16, ll16;

   always_comb begin
      ec16 = '0;
      hl16 = '0;
      ll16 = '0;
      ec16[CNT_W-1:0] = cnt_q;
      hl16[CNT_W-1:0] = hl_w;
      ll16[CNT_W-1:0] = ll_w;
      data_d = data_q;
      if (ena) begin
         case (sel)
            3'd0:    data_d = ec16[7:0];
            3'd1:    data_d = ec16[15:8];
            3'd2:    data_d = hl16[7:0];
            3'd3:    data_d = hl16[15:8];
            3'd4:    data_d = ll16[7:0];
            3'd5:    data_d = ll16[15:8];
            3'd6:    data_d = {3'b000, ps_w, lv_w, hv_w, ovf_q, level_q};
            default: data_d = ID_BYTE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         deb_q <= '0; level_q <= 1'b0; pulse_q <= 1'b0;
         cnt_q <= '0; ovf_q   <= 1'b0; data_q  <= '0;
      end else begin
         deb_q <= deb_d; level_q <= level_d; pulse_q <= pulse_d;
         cnt_q <= cnt_d; ovf_q   <= ovf_d;   data_q  <= data_d;
      end

   assign data_out   = data_q;
   assign level_out  = level_q;
   assign edge_pulse = pulse_q;
   assign ovf        = ovf_q;
endmodule

// File: tb/tb_inv_out_monitor.sv
// Bench for inv_out_monitor: a 16-bit and an 8-bit counter instance share one stimulus stream;
// expectations come from a segment-level model of the sense_in waveform.
module tb_inv_out_monitor;
   localparam int SYNC = 2;
   localparam int DEB  = 4;

   logic       clk = 1'b0;
   logic       rst_n, ena, sense_in, clr;
   logic [2:0] sel;
   logic [7:0] data_out, data_out8;
   logic       level_out, level_out8, edge_pulse, edge_pulse8, ovf, ovf8;
   int         n_cmp = 0;
   int         n_err = 0;
   logic       mdl_level;
   logic       seg_v[$];
   int         seg_l[$];

   always #5 clk = ~clk;

   inv_out_monitor #(.SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sense_in(sense_in), .clr(clr), .sel(sel),
      .data_out(data_out), .level_out(level_out), .edge_pulse(edge_pulse), .ovf(ovf));

   inv_out_monitor #(.SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .CNT_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sense_in(sense_in), .clr(clr), .sel(sel),
      .data_out(data_out8), .level_out(level_out8), .edge_pulse(edge_pulse8), .ovf(ovf8));

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold(input logic v, input int n);
      sense_in = v;
      tick(n);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
   endtask

   task automatic read_sel(input int s, output logic [7:0] b16, output logic [7:0] b8);
      sel = 3'(s);
      tick(1);
      b16 = data_out;
      b8  = data_out8;
   endtask

   function automatic logic [7:0] exp_byte(input int s, input int mx, input int edges, input int hl,
                                           input int ll, input bit hv, input bit lv, input int maxlen,
                                           input bit lvl);
      int ec, h, l;
      bit ov, ps;
      ec = (edges > mx) ? mx : edges;
      ov = edges > mx;
      h  = (hl > mx) ? mx : hl;
      l  = (ll > mx) ? mx : ll;
      ps = maxlen >= mx;
`ifndef PERIOD_MEAS_EN
      h = 0; l = 0; hv = 0; lv = 0; ps = 0;
`endif
      case (s)
         0:       exp_byte = ec[7:0];
         1:       exp_byte = ec[15:8];
         2:       exp_byte = h[7:0];
         3:       exp_byte = h[15:8];
         4:       exp_byte = l[7:0];
         5:       exp_byte = l[15:8];
         6:       exp_byte = {3'b000, ps, lv, hv, ov, lvl};
         default: exp_byte = 8'hA5;
      endcase
   endfunction

   task automatic test_reset();
      logic [7:0] b16, b8;
      rst_n = 1'b0; ena = 1'b1; sense_in = 1'b0; clr = 1'b0; sel = 3'd0;
      tick(3);
      n_cmp++;
      if ({data_out, level_out, edge_pulse, ovf} !== 11'h0) begin
         n_err++; $display("FAIL reset_hold: got %h expected 000", {data_out, level_out, edge_pulse, ovf});
      end
      rst_n = 1'b1;
      hold(1'b1, 10);
      #2 rst_n = 1'b0;
      sense_in = 1'b0;
      #1;
      n_cmp++;
      if ({data_out, data_out8, level_out, edge_pulse, ovf} !== 19'h0) begin
         n_err++; $display("FAIL reset_async: got %h/%h lvl %b expected 00/00 lvl 0", data_out, data_out8, level_out);
      end
      tick(2);
      rst_n = 1'b1;
      n_cmp++;
      if ({data_out, level_out, edge_pulse, ovf} !== 11'h0) begin
         n_err++; $display("FAIL reset_release: got %h expected 000", {data_out, level_out, edge_pulse, ovf});
      end
      read_sel(7, b16, b8);
      n_cmp++;
      if (b16 !== 8'hA5 || b8 !== 8'hA5) begin
         n_err++; $display("FAIL id_byte: got %h/%h expected a5/a5", b16, b8);
      end
      read_sel(0, b16, b8);
      n_cmp++;
      if (b16 !== 8'h00) begin
         n_err++; $display("FAIL reset_cnt: got %h expected 00", b16);
      end
   endtask

   task automatic test_glitch();
      logic [7:0] b16, b8;
      bit seen;
      int first, npulse, pidx;
      hold(1'b1, 3);
      sense_in = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (level_out !== 1'b0) seen = 1;
      end
      n_cmp++;
      if (seen) begin n_err++; $display("FAIL glitch_level: got rise expected none"); end
      read_sel(0, b16, b8);
      n_cmp++;
      if (b16 !== 8'h00) begin n_err++; $display("FAIL glitch_cnt: got %h expected 00", b16); end
      sense_in = 1'b1;
      first = -1; npulse = 0; pidx = -1;
      for (int i = 1; i <= 14; i++) begin
         tick(1);
         if (level_out === 1'b1 && first < 0) first = i;
         if (edge_pulse === 1'b1) begin npulse++; pidx = i; end
         if (i == 10) sense_in = 1'b0;
      end
      n_cmp++;
      if (first != SYNC + DEB) begin
         n_err++; $display("FAIL rise_latency: got %0d expected %0d", first, SYNC + DEB);
      end
      n_cmp++;
      if (npulse != 1 || pidx != SYNC + DEB) begin
         n_err++; $display("FAIL edge_pulse: got %0d pulses at %0d expected 1 at %0d", npulse, pidx, SYNC + DEB);
      end
      hold(1'b0, 10);
      read_sel(0, b16, b8);
      n_cmp++;
      if (b16 !== 8'h01) begin n_err++; $display("FAIL pulse_cnt: got %h expected 01", b16); end
   endtask

   task automatic test_edge_count();
      logic [7:0] b16, b8;
      pulse_clr();
      repeat (10) begin hold(1'b1, 20); hold(1'b0, 20); end
      read_sel(0, b16, b8);
      n_cmp++;
      if (b16 !== 8'h0A || b8 !== 8'h0A) begin
         n_err++; $display("FAIL edge_cnt_lo: got %h/%h expected 0a/0a", b16, b8);
      end
      read_sel(1, b16, b8);
      n_cmp++;
      if (b16 !== 8'h00 || ovf !== 1'b0) begin
         n_err++; $display("FAIL edge_cnt_hi: got %h ovf %b expected 00 ovf 0", b16, ovf);
      end
   endtask

   task automatic test_period();
      logic [7:0] b16, b8;
      logic [7:0] e16[5], e8[5];
`ifdef PERIOD_MEAS_EN
      e16 = '{8'h25, 8'h00, 8'h2C, 8'h01, 8'h0D};
      e8  = '{8'h25, 8'h00, 8'hFF, 8'h00, 8'h1D};
`else
      e16 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      e8  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
`endif
      pulse_clr();
      hold(1'b1, 20); hold(1'b0, 20);
      hold(1'b1, 37); hold(1'b0, 300); hold(1'b1, 20);
      for (int s = 2; s <= 6; s++) begin
         read_sel(s, b16, b8);
         n_cmp++;
         if (b16 !== e16[s-2] || b8 !== e8[s-2]) begin
            n_err++; $display("FAIL period_sel%0d: got %h/%h expected %h/%h", s, b16, b8, e16[s-2], e8[s-2]);
         end
      end
      hold(1'b0, 20);
   endtask

   task automatic test_saturation();
      logic [7:0] b16, b8, c16, c8;
      pulse_clr();
      repeat (257) begin hold(1'b1, 6); hold(1'b0, 6); end
      hold(1'b0, 10);
      read_sel(0, b16, b8);
      read_sel(1, c16, c8);
      n_cmp++;
      if (b8 !== 8'hFF || ovf8 !== 1'b1 || c8 !== 8'h00) begin
         n_err++; $display("FAIL sat8: got %h%h ovf %b expected 00ff ovf 1", c8, b8, ovf8);
      end
      n_cmp++;
      if (b16 !== 8'h01 || c16 !== 8'h01 || ovf !== 1'b0) begin
         n_err++; $display("FAIL cnt16_257: got %h%h ovf %b expected 0101 ovf 0", c16, b16, ovf);
      end
      pulse_clr();
      read_sel(0, b16, b8);
      n_cmp++;
      if (b8 !== 8'h00 || ovf8 !== 1'b0) begin
         n_err++; $display("FAIL clr_sat: got %h ovf %b expected 00 ovf 0", b8, ovf8);
      end
      hold(1'b1, 10); hold(1'b0, 10);
      sense_in = 1'b1;
      for (int i = 1; i <= SYNC + DEB; i++) begin
         tick(1);
         if (i == SYNC + DEB - 1) clr = 1'b1;
         if (i == SYNC + DEB) begin
            n_cmp++;
            if (edge_pulse !== 1'b1 || edge_pulse8 !== 1'b1) begin
               n_err++; $display("FAIL clr_edge_pulse: got %b/%b expected 1/1", edge_pulse, edge_pulse8);
            end
            clr = 1'b0;
         end
      end
      hold(1'b1, 10);
      read_sel(0, b16, b8);
      n_cmp++;
      if (b16 !== 8'h00 || b8 !== 8'h00) begin
         n_err++; $display("FAIL clr_edge_cnt: got %h/%h expected 00/00", b16, b8);
      end
      read_sel(6, b16, b8);
      n_cmp++;
      if (b16 !== 8'h01 || b8 !== 8'h01) begin
         n_err++; $display("FAIL clr_edge_status: got %h/%h expected 01/01", b16, b8);
      end
      hold(1'b0, 15);
   endtask

   task automatic test_ena();
      logic [7:0] b16, b8;
      bit moved;
      pulse_clr();
      repeat (2) begin hold(1'b1, 10); hold(1'b0, 10); end
      read_sel(0, b16, b8);
      n_cmp++;
      if (b16 !== 8'h02) begin n_err++; $display("FAIL ena_pre: got %h expected 02", b16); end
      ena = 1'b0;
      sel = 3'd7;
      moved = 0;
      for (int i = 0; i < 50; i++) begin
         sense_in = ((i % 10) < 5);
         tick(1);
         if (level_out !== 1'b0 || edge_pulse !== 1'b0) moved = 1;
      end
      n_cmp++;
      if (moved || data_out !== 8'h02) begin
         n_err++; $display("FAIL ena_freeze: got data %h moved %b expected data 02 moved 0", data_out, moved);
      end
      sense_in = 1'b0;
      ena = 1'b1;
      tick(10);
      read_sel(0, b16, b8);
      n_cmp++;
      if (b16 !== 8'h02 || b8 !== 8'h02) begin
         n_err++; $display("FAIL ena_post: got %h/%h expected 02/02", b16, b8);
      end
      mdl_level = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0] b16, b8, e16, e8;
      int nseg, edges, hl, ll, t, t_last, len, maxlen;
      bit f, hv, lv, act;
      for (int r = 0; r < 8; r++) begin
         pulse_clr();
         seg_v.delete();
         seg_l.delete();
         nseg = $urandom_range(6, 20);
         for (int k = 0; k < nseg; k++) begin
            seg_v.push_back((k % 2 == 0) ? !mdl_level : mdl_level);
            seg_l.push_back($urandom_range(1, 10));
         end
         foreach (seg_v[k]) hold(seg_v[k], seg_l[k]);
         f = mdl_level; act = 0; edges = 0; hl = 0; ll = 0; hv = 0; lv = 0;
         t = 0; t_last = 0; maxlen = 0;
         foreach (seg_v[k]) begin
            if (seg_v[k] != f && seg_l[k] >= DEB) begin
               if (act) begin
                  len = t - t_last;
                  if (f) begin hl = len; hv = 1; end
                  else   begin ll = len; lv = 1; end
                  if (len > maxlen) maxlen = len;
               end
               act = 1;
               t_last = t;
               f = seg_v[k];
               if (f) edges++;
            end
            t += seg_l[k];
         end
         hold(f, 15);
         mdl_level = f;
         n_cmp++;
         if (level_out !== f || level_out8 !== f) begin
            n_err++; $display("FAIL rnd%0d_level: got %b/%b expected %b", r, level_out, level_out8, f);
         end
         for (int s = 0; s < 7; s++) begin
            read_sel(s, b16, b8);
            e16 = exp_byte(s, 65535, edges, hl, ll, hv, lv, maxlen, f);
            e8  = exp_byte(s, 255, edges, hl, ll, hv, lv, maxlen, f);
            n_cmp++;
            if (b16 !== e16 || b8 !== e8) begin
               n_err++; $display("FAIL rnd%0d_sel%0d: got %h/%h expected %h/%h", r, s, b16, b8, e16, e8);
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_glitch();
      test_edge_count();
      test_period();
      test_saturation();
      test_ena();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
